// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// EX-stage operand forwarding and hazard controller for the pipelined RV32 core.
// Each source in EX picks the youngest producer stage writing its register, and
// x0 is never forwarded. Load-use hazards insert 1+LOAD_EXTRA bubbles. A busy data
// memory freezes the whole pipeline and suspends any stall sequence in progress.
// Two saturating counters record bubble cycles and freeze cycles.
module hazard_forward_unit #(
  parameter  int REG_AW     = 5,
  parameter  int NUM_SRC    = 2,
  parameter  int FWD_STAGES = 2,
  parameter  int LOAD_EXTRA = 0,
  parameter  int CNT_W      = 16,
  localparam int SELW       = $clog2(FWD_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_SRC*REG_AW-1:0]    ex_rs,
  input  logic [FWD_STAGES*REG_AW-1:0] stg_rd,
  input  logic [FWD_STAGES-1:0]        stg_regwrite,
  input  logic [NUM_SRC*REG_AW-1:0]    id_rs,
  input  logic [NUM_SRC-1:0]           id_rs_used,
  input  logic [REG_AW-1:0]            ex_rd,
  input  logic                         ex_regwrite,
  input  logic                         ex_memread,
  input  logic                         mem_busy,
  input  logic                         perf_clr,
  output logic [NUM_SRC*SELW-1:0]      fwd_sel,
  output logic                         hold_if,
  output logic                         flush_idex,
  output logic                         freeze_all,
  output logic [CNT_W-1:0]             lu_stall_cnt,
  output logic [CNT_W-1:0]             mem_stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t     state;
  state_t     resume;
  state_t     eval_state;
  logic [2:0] rem;
  logic       lu;

  // Per source, select the youngest matching producer stage (scan oldest first so younger overwrites).
  always_comb begin
    // NOTE: the output gets a default before any conditional update, so no latch is inferred.
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (rstn && stg_regwrite[k] &&
            (stg_rd[k*REG_AW +: REG_AW] == ex_rs[i*REG_AW +: REG_AW]) &&
            (ex_rs[i*REG_AW +: REG_AW] != '0)) begin
          fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
        end
      end
    end
  end

  // Load-use detection: a load in EX writes a register that the ID instruction reads.
  always_comb begin
    lu = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] == ex_rd)) lu = 1'b1;
    end
    lu = lu && ex_memread && ex_regwrite && (ex_rd != '0);
  end

  // The cycle memory becomes ready, behave exactly as the state that was suspended.
  always_comb begin
    eval_state = state;
    if ((state == MEM_WAIT) && !mem_busy) eval_state = resume;
  end

  // Control outputs: freeze has priority, otherwise bubble while stalling or on a new hazard.
  always_comb begin
    hold_if    = 1'b0;
    flush_idex = 1'b0;
    freeze_all = 1'b0;
    if (rstn) begin
      if (mem_busy) begin
        freeze_all = 1'b1;
        hold_if    = 1'b1;
      end else if ((eval_state == LU_STALL) || ((eval_state == RUN) && lu)) begin
        hold_if    = 1'b1;
        flush_idex = 1'b1;
      end
    end
  end

  // Stall sequencer: remembers the state interrupted by a memory freeze and counts extra bubbles.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      state  <= RUN;
      resume <= RUN;
      rem    <= 3'd0;
    end else if (mem_busy) begin
      if (state != MEM_WAIT) begin
        resume <= state;
        state  <= MEM_WAIT;
      end
    end else begin
      case (eval_state)
        RUN: begin
          if (lu && (LOAD_EXTRA != 0)) begin
            state <= LU_STALL;
            rem   <= 3'(LOAD_EXTRA);
          end else begin
            state <= RUN;
          end
        end
        LU_STALL: begin
          rem <= rem - 3'd1;
          if (rem == 3'd1) state <= RUN;
          else             state <= LU_STALL;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Bubble-cycle counter, saturating; clear wins over increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                  lu_stall_cnt <= '0;
    else if (perf_clr)                          lu_stall_cnt <= '0;
    else if (flush_idex && (lu_stall_cnt != '1)) lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
  end

  // Freeze-cycle counter, saturating; clear wins over increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                    mem_stall_cnt <= '0;
    else if (perf_clr)                            mem_stall_cnt <= '0;
    else if (freeze_all && (mem_stall_cnt != '1)) mem_stall_cnt <= mem_stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Testbench for hazard_forward_unit. A driver applies one stimulus vector per cycle.
// A reference model predicts the response of that cycle and queues it. A monitor
// samples the DUT on the falling edge and compares it against the queued response.
module tb_hazard_forward_unit;

  localparam int REG_AW     = 5;
  localparam int NUM_SRC    = 2;
  localparam int FWD_STAGES = 2;
  localparam int LOAD_EXTRA = 2;
  localparam int CNT_W      = 4;
  localparam int SELW       = 2;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rstn;
  logic [NUM_SRC*REG_AW-1:0]    ex_rs;
  logic [FWD_STAGES*REG_AW-1:0] stg_rd;
  logic [FWD_STAGES-1:0]        stg_regwrite;
  logic [NUM_SRC*REG_AW-1:0]    id_rs;
  logic [NUM_SRC-1:0]           id_rs_used;
  logic [REG_AW-1:0]            ex_rd;
  logic                         ex_regwrite, ex_memread, mem_busy, perf_clr;
  logic [NUM_SRC*SELW-1:0]      fwd_sel;
  logic                         hold_if, flush_idex, freeze_all;
  logic [CNT_W-1:0]             lu_stall_cnt, mem_stall_cnt;

  hazard_forward_unit #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES),
    .LOAD_EXTRA(LOAD_EXTRA), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .ex_rs(ex_rs), .stg_rd(stg_rd), .stg_regwrite(stg_regwrite),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .mem_busy(mem_busy), .perf_clr(perf_clr),
    .fwd_sel(fwd_sel), .hold_if(hold_if), .flush_idex(flush_idex), .freeze_all(freeze_all),
    .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
  );

  typedef struct {
    bit       rstn;
    bit [4:0] rs0, rs1, sd0, sd1, irs0, irs1, erd;
    bit [1:0] srw, used;
    bit       erw, emr, busy, clr;
  } stim_t;

  typedef struct {
    int fwd0, fwd1;
    bit hold, flush, freeze;
    int lu_cnt, mem_cnt;
  } exp_t;

  stim_t s;
  exp_t  sb_q[$];
  int    n_vectors = 0;
  int    n_checks  = 0;
  int    n_fail    = 0;

  // Reference model state: bubbles still owed and the two counters.
  int m_pending = 0;
  int m_lu      = 0;
  int m_mem     = 0;

  function automatic void set_nop();
    s.rstn = 1'b1;
    s.rs0 = 0; s.rs1 = 0; s.sd0 = 0; s.sd1 = 0; s.irs0 = 0; s.irs1 = 0; s.erd = 0;
    s.srw = 0; s.used = 0; s.erw = 0; s.emr = 0; s.busy = 0; s.clr = 0;
  endfunction

  // Youngest stage that writes the register wins; register 0 never forwards.
  function automatic int fwd_ref(input bit [4:0] rs);
    if (rs == 0) return 0;
    if (s.srw[0] && (s.sd0 == rs)) return 1;
    if (s.srw[1] && (s.sd1 == rs)) return 2;
    return 0;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  function automatic void model(output exp_t e);
    bit lu;
    e.fwd0 = 0; e.fwd1 = 0; e.hold = 0; e.flush = 0; e.freeze = 0; e.lu_cnt = 0; e.mem_cnt = 0;
    if (!s.rstn) begin
      m_pending = 0; m_lu = 0; m_mem = 0;
      return;
    end
    e.fwd0 = fwd_ref(s.rs0);
    e.fwd1 = fwd_ref(s.rs1);
    lu = s.emr && s.erw && (s.erd != 0) &&
         ((s.used[0] && (s.irs0 == s.erd)) || (s.used[1] && (s.irs1 == s.erd)));
    if (s.busy) begin
      e.freeze = 1; e.hold = 1;
    end else if (m_pending > 0) begin
      e.hold = 1; e.flush = 1; m_pending--;
    end else if (lu) begin
      e.hold = 1; e.flush = 1; m_pending = LOAD_EXTRA;
    end
    e.lu_cnt  = m_lu;
    e.mem_cnt = m_mem;
    if (s.clr) begin
      m_lu = 0; m_mem = 0;
    end else begin
      if (e.flush)  m_lu  = sat_inc(m_lu);
      if (e.freeze) m_mem = sat_inc(m_mem);
    end
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    rstn         = s.rstn;
    ex_rs        = {s.rs1, s.rs0};
    stg_rd       = {s.sd1, s.sd0};
    stg_regwrite = s.srw;
    id_rs        = {s.irs1, s.irs0};
    id_rs_used   = s.used;
    ex_rd        = s.erd;
    ex_regwrite  = s.erw;
    ex_memread   = s.emr;
    mem_busy     = s.busy;
    perf_clr     = s.clr;
    model(e);
    sb_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one queued response per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vectors++;
        check("fwd_sel0",      32'(fwd_sel[1:0]), e.fwd0);
        check("fwd_sel1",      32'(fwd_sel[3:2]), e.fwd1);
        check("hold_if",       32'(hold_if),      int'(e.hold));
        check("flush_idex",    32'(flush_idex),   int'(e.flush));
        check("freeze_all",    32'(freeze_all),   int'(e.freeze));
        check("lu_stall_cnt",  32'(lu_stall_cnt), e.lu_cnt);
        check("mem_stall_cnt", 32'(mem_stall_cnt), e.mem_cnt);
      end
    end
  end

  // Load x3 in EX, ID reads x3 and x1.
  function automatic void set_lu();
    set_nop();
    s.emr = 1; s.erw = 1; s.erd = 3; s.irs0 = 3; s.irs1 = 1; s.used = 2'b11;
  endfunction

  initial begin
    rstn = 1'b0; ex_rs = '0; stg_rd = '0; stg_regwrite = '0; id_rs = '0; id_rs_used = '0;
    ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0; mem_busy = 1'b0; perf_clr = 1'b0;

    // Reset state.
    set_nop(); s.rstn = 0; tick(); tick();

    // Youngest stage wins.
    set_nop(); s.rs0 = 5; s.sd0 = 5; s.sd1 = 5; s.srw = 2'b11; tick();
    // x0 never forwarded; source 1 matches stage 1 only.
    set_nop(); s.rs0 = 0; s.sd0 = 0; s.rs1 = 7; s.sd1 = 7; s.srw = 2'b11; tick();
    set_nop(); s.rs0 = 9; s.rs1 = 9; s.sd0 = 9; s.srw = 2'b10; s.sd1 = 9; tick();

    // Load-use with two extra cycles: three bubbles.
    set_lu(); tick();
    set_nop(); s.irs0 = 3; s.irs1 = 1; s.used = 2'b11; repeat (4) tick();

    // Hazard and memory busy together for four cycles, then the bubbles.
    set_nop(); s.clr = 1; tick();
    set_lu(); s.busy = 1; repeat (4) tick();
    set_lu(); tick();
    set_nop(); repeat (4) tick();

    // Memory busy in the last stall cycle: one more bubble after release.
    set_lu(); tick();
    set_nop(); tick();
    set_nop(); s.busy = 1; repeat (3) tick();
    set_nop(); repeat (3) tick();

    // Reset in the middle of a stall.
    set_lu(); tick();
    set_nop(); tick();
    set_lu(); s.rstn = 0; repeat (2) tick();
    set_nop(); repeat (3) tick();

    // Saturation: freeze past the counter maximum, then clear (clear beats increment).
    set_nop(); s.busy = 1; repeat (CNT_MAX + 3) tick();
    set_nop(); s.busy = 1; s.clr = 1; tick();
    set_nop(); repeat (2) tick();

    // Randomized traffic over a small register set to force frequent matches.
    for (int n = 0; n < 3000; n++) begin
      s.rstn = ($urandom_range(0, 99) != 0);
      s.rs0  = 5'($urandom_range(0, 3));
      s.rs1  = 5'($urandom_range(0, 3));
      s.sd0  = 5'($urandom_range(0, 3));
      s.sd1  = 5'($urandom_range(0, 3));
      s.irs0 = 5'($urandom_range(0, 3));
      s.irs1 = 5'($urandom_range(0, 3));
      s.erd  = 5'($urandom_range(0, 3));
      s.srw  = 2'($urandom_range(0, 3));
      s.used = 2'($urandom_range(0, 3));
      s.erw  = ($urandom_range(0, 3) != 0);
      s.emr  = ($urandom_range(0, 1) != 0);
      s.busy = ($urandom_range(0, 5) == 0);
      s.clr  = ($urandom_range(0, 29) == 0);
      tick();
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 10; w++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses still pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
    $finish;
  end

endmodule
